// File: rtl/apb_multi_bridge.sv
// apb_multi_bridge
//
// Bridges a simple valid/ready host request onto an APB bus that is shared by
// NUM_SLAVES slaves. The top SEL_W bits of req_addr select the slave and the
// low SLV_ADDR_W bits are driven on PADDR. If the slave index is out of range,
// the request completes with an error and no PSEL is asserted.
//
// Optional feature: define APB_TIMEOUT_EN to bound each ACCESS phase to
// TIMEOUT_CYCLES cycles. A transfer that reaches the bound is forced to
// complete with rsp_err=1. When the macro is undefined, no counter exists and
// ACCESS waits for PREADY indefinitely.
//
// Ports
//   PCLK, PRESETn       clock, asynchronous active-low reset
//   req_valid/req_ready host request handshake (req_ready high only in IDLE)
//   req_write           1 = write, 0 = read
//   req_addr            {slave index, offset}
//   req_wdata           write data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  read data and error flag, valid with rsp_valid
//   PADDR, PWRITE, PWDATA, PENABLE   shared APB request bus
//   PSEL                one-hot slave select
//   PRDATA, PREADY, PSLVERR          per-slave responses (slave i at slice i)

module apb_multi_bridge #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SLV_ADDR_W     = 5,
    parameter int unsigned SEL_W          = 3,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [SEL_W+SLV_ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         req_ready,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [SLV_ADDR_W-1:0]        PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDecerr
    } state_e;

    state_e state_q;

    // Request decode
    logic [SEL_W-1:0]      req_idx;
    logic [31:0]           req_idx_ext;
    logic                  req_in_range;
    logic [NUM_SLAVES-1:0] psel_dec;

    assign req_idx      = req_addr[SEL_W+SLV_ADDR_W-1 -: SEL_W];
    assign req_idx_ext  = 32'(req_idx);
    assign req_in_range = (req_idx_ext < NUM_SLAVES);

    always_comb begin
        psel_dec = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            psel_dec[i] = (req_idx_ext == 32'(i));
        end
    end

    // Response mux. PSEL is registered one-hot, so masking by it picks the
    // active slave and ignores everything the unselected slaves drive.
    logic              pready_sel;
    logic              pslverr_sel;
    logic [DATA_W-1:0] prdata_sel;

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (PSEL[i]) begin
                prdata_sel = prdata_sel | PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign pready_sel  = |(PREADY & PSEL);
    assign pslverr_sel = |(PSLVERR & PSEL);

    assign req_ready = (state_q == StIdle);

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q;
    logic            tmo_hit;

    // True in the ACCESS cycle that would be number TIMEOUT_CYCLES
    assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            // Response fields are pulses; they only carry data with rsp_valid
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (req_in_range) begin
                            state_q <= StSetup;
                            PSEL    <= psel_dec;
                            PENABLE <= 1'b0;
                            PADDR   <= req_addr[SLV_ADDR_W-1:0];
                            PWRITE  <= req_write;
                            PWDATA  <= req_wdata;
                        end else begin
                            state_q <= StDecerr;
                        end
                    end
                end

                StSetup: begin
                    state_q <= StAccess;
                    PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end

                StAccess: begin
                    if (pready_sel) begin
                        // PREADY wins over a simultaneous timeout
                        state_q   <= StIdle;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr_sel;
                        rsp_rdata <= PWRITE ? '0 : prdata_sel;
`ifdef APB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state_q   <= StIdle;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end

                StDecerr: begin
                    state_q   <= StIdle;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end

                default: begin
                    state_q <= StIdle;
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule
